// File: rtl/chip8_selftest.sv
// On-chip test sequencer for chip8: loads a program into ram1, pulses the CPU reset, then checks the LED bus at set cycles.
// Optional build macro CHIP8_SELFTEST_CONTINUE_EN: evaluate every checkpoint and expose a mismatch count.
module chip8_selftest #(
  parameter int unsigned                    ADDR_W       = 12,
  parameter int unsigned                    DATA_W       = 8,
  parameter logic [ADDR_W-1:0]              LOAD_BASE    = 12'h200,
  parameter int unsigned                    PROG_LEN     = 16,
  parameter int unsigned                    RESET_CYCLES = 4,
  parameter int unsigned                    NUM_CHECKS   = 2,
  parameter int unsigned                    CYC_W        = 16,
  parameter logic [NUM_CHECKS*CYC_W-1:0]    CHECK_CYCLES = {16'd3, 16'd1},
  parameter logic [NUM_CHECKS*8-1:0]        CHECK_VALUES = {8'd88, 8'd0}
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              start,
  input  logic              prog_valid,
  input  logic [DATA_W-1:0] prog_data,
  output logic              prog_ready,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  output logic              cpu_reset_n,
  input  logic [7:0]        led_in,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [3:0]        fail_index,
  output logic [7:0]        fail_value
`ifdef CHIP8_SELFTEST_CONTINUE_EN
  ,
  output logic [4:0]        fail_count
`endif
);

  localparam int unsigned CNT_W = $clog2(PROG_LEN + 1);
  localparam int unsigned RST_W = $clog2(RESET_CYCLES + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_RST  = 3'd2;
  localparam logic [2:0] S_RUN  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]       state;
  logic [CNT_W-1:0] count;
  logic [RST_W-1:0] rst_cnt;
  logic [CYC_W-1:0] run_cnt;
  logic [3:0]       idx;

  logic [CYC_W-1:0] cur_cyc;
  logic [7:0]       cur_val;
  logic             beat_acc;
  logic             hit;
  logic             match;
  logic             last;
  logic             sat;

  assign prog_ready = (state == S_LOAD) && (count < CNT_W'(PROG_LEN));
  assign beat_acc   = prog_valid && prog_ready;

  // Select the active checkpoint's offset and expected LED value
  always_comb begin
    cur_cyc = '0;
    cur_val = '0;
    for (int unsigned i = 0; i < NUM_CHECKS; i++) begin
      if (idx == 4'(i)) begin
        cur_cyc = CHECK_CYCLES[i*CYC_W +: CYC_W];
        cur_val = CHECK_VALUES[i*8 +: 8];
      end
    end
  end

  assign hit   = (run_cnt == cur_cyc);
  assign match = (led_in == cur_val);
  assign last  = (idx == 4'(NUM_CHECKS - 1));
  assign sat   = &run_cnt;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state       <= S_IDLE;
      count       <= '0;
      rst_cnt     <= '0;
      run_cnt     <= '0;
      idx         <= '0;
      ram_address <= '0;
      ram_data    <= '0;
      ram_wren    <= 1'b0;
      cpu_reset_n <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail_index  <= '0;
      fail_value  <= '0;
`ifdef CHIP8_SELFTEST_CONTINUE_EN
      fail_count  <= '0;
`endif
    end else begin
      ram_wren <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state       <= S_LOAD;
            count       <= '0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail_index  <= '0;
            fail_value  <= '0;
            busy        <= 1'b1;
            cpu_reset_n <= 1'b0;
`ifdef CHIP8_SELFTEST_CONTINUE_EN
            fail_count  <= '0;
`endif
          end
        end

        S_LOAD: begin
          if (beat_acc) begin
            ram_wren    <= 1'b1;
            ram_address <= LOAD_BASE + ADDR_W'(count);
            ram_data    <= prog_data;
            count       <= count + 1'b1;
            if (count == CNT_W'(PROG_LEN - 1)) begin
              state   <= S_RST;
              rst_cnt <= '0;
            end
          end
        end

        // The final beat's write lands in the first RST cycle
        S_RST: begin
          if (rst_cnt == RST_W'(RESET_CYCLES - 1)) begin
            cpu_reset_n <= 1'b1;
            state       <= S_RUN;
            run_cnt     <= '0;
            idx         <= '0;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end

        S_RUN: begin
          if (!sat) run_cnt <= run_cnt + 1'b1;
          if (hit) begin
`ifdef CHIP8_SELFTEST_CONTINUE_EN
            if (!match) begin
              if (fail_count == '0) begin
                fail_index <= idx;
                fail_value <= led_in;
              end
              fail_count <= fail_count + 1'b1;
            end
            if (last) begin
              pass  <= match && (fail_count == '0);
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              idx <= idx + 1'b1;
            end
`else
            if (!match) begin
              fail_index <= idx;
              fail_value <= led_in;
              state      <= S_DONE;
              done       <= 1'b1;
              busy       <= 1'b0;
            end else if (last) begin
              pass  <= 1'b1;
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              idx <= idx + 1'b1;
            end
`endif
          end else if (sat) begin
            // Ran out of cycles before the remaining checkpoints were reached
`ifdef CHIP8_SELFTEST_CONTINUE_EN
            if (fail_count == '0) begin
              fail_index <= idx;
              fail_value <= led_in;
            end
`else
            fail_index <= idx;
            fail_value <= led_in;
`endif
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/chip8_selftest.md
Name: chip8_selftest

Overview:
On-chip, synthesisable test sequencer that supersedes the fixed reset-then-check bench flow used for the chip8 core. It streams a program image into ram1 port A, holds the chip8 in reset while loading, releases it, then compares the chip8 LED bus against a parametrised list of expected values at given cycle offsets. It sits between a program source (host/ROM streamer) and the chip8/ram1 pair, and reports pass/fail plus the failing check and value.

Parameters:
ADDR_W, 12, ram1 address width
DATA_W, 8, ram1 data width and program beat width
LOAD_BASE, 12'h200, first ram1 address written
PROG_LEN, 16, program beats per run (1..2^ADDR_W-LOAD_BASE)
RESET_CYCLES, 4, cycles cpu_reset_n held low after load completes (>=1)
NUM_CHECKS, 2, number of checkpoints (1..16)
CYC_W, 16, width of run-cycle counter and of each checkpoint offset
CHECK_CYCLES, {16'd3,16'd1}, packed NUM_CHECKS x CYC_W offsets; entry i at bits [i*CYC_W +: CYC_W]; strictly increasing in i
CHECK_VALUES, {8'd88,8'd0}, packed NUM_CHECKS x 8 expected LED values, entry i at [i*8 +: 8]

Ports:
CLOCK_50  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high
start  input  1  one-cycle request to begin a run; honoured only in IDLE or DONE
prog_valid  input  1  program beat valid
prog_data  input  DATA_W  program beat
prog_ready  output  1  block accepts beat this cycle
ram_address  output  ADDR_W  to ram1 address_a (muxed with chip8 externally by busy)
ram_data  output  DATA_W  to ram1 data_a
ram_wren  output  1  to ram1 wren_a
cpu_reset_n  output  1  to chip8 reset (KEY[0]), active-low
led_in  input  8  chip8 LED bus
busy  output  1  run in progress (LOAD/RST/RUN)
done  output  1  run finished, results valid
pass  output  1  all checks matched (valid when done)
fail_index  output  4  first failing checkpoint index
fail_value  output  8  led_in captured at first failure

Behaviour:
- Reset values: prog_ready=0, ram_address=0, ram_data=0, ram_wren=0, cpu_reset_n=0, busy=0, done=0, pass=0, fail_index=0, fail_value=0; state IDLE. All outputs registered except prog_ready (=1 exactly when state==LOAD and beat count<PROG_LEN).
- States: IDLE -> LOAD -> RST -> RUN -> DONE -> (start) LOAD.
- IDLE/DONE: start=1 -> LOAD next cycle; beat count=0, done=0, pass=0, fail_index=0, fail_value=0, busy=1, cpu_reset_n=0.
- LOAD: beat accepted when prog_valid&&prog_ready. Cycle after acceptance: ram_wren=1, ram_address=LOAD_BASE+count (mod 2^ADDR_W), ram_data=beat; ram_wren=0 in cycles with no acceptance. Back-to-back beats give one write per cycle. After beat PROG_LEN accepted -> RST (final write still issued in first RST cycle).
- RST: cpu_reset_n=0 for RESET_CYCLES cycles, then cpu_reset_n=1 and -> RUN with run counter=0, check index=0.
- RUN: run counter increments each cycle (saturates at all-ones). When counter==CHECK_CYCLES[idx]: compare led_in to CHECK_VALUES[idx]. Mismatch -> fail_index=idx, fail_value=led_in, -> DONE. Match and idx==NUM_CHECKS-1 -> pass=1, -> DONE; else idx++.
- Counter saturating before final check -> DONE, pass=0, fail_index=idx, fail_value=led_in.
- DONE: done=1, busy=0, cpu_reset_n stays 1 (CPU keeps running), results held until next start.
- start during LOAD/RST/RUN ignored. reset in any state -> reset values next cycle; an in-flight write is dropped (ram_wren=0).

Optional Feature:
CHIP8_SELFTEST_CONTINUE_EN: defined -> mismatches do not terminate RUN; every checkpoint is evaluated, extra output fail_count (5 bits, reset 0, cleared on start) counts mismatches, fail_index/fail_value hold the first mismatch, pass=1 only if fail_count==0 at DONE. Undefined -> stop on first mismatch, no fail_count port.

Test Plan:
- reset high 2 cycles mid-RUN -> next cycle cpu_reset_n=0, busy=0, done=0, ram_wren=0, state IDLE.
- start, 16 back-to-back beats 0x00..0x0F -> ram_wren pulses 16 consecutive cycles, addresses 0x200..0x20F, data matching; cpu_reset_n low exactly 4 cycles after final write cycle.
- prog_valid toggling every other cycle -> writes only for accepted beats, addresses contiguous, no duplicates.
- led_in=0 at run cycle 1, 88 at run cycle 3 -> done=1, pass=1.
- led_in=87 at run cycle 3 -> done=1, pass=0, fail_index=1, fail_value=87; with CHIP8_SELFTEST_CONTINUE_EN and led_in=5 at cycle 1 also -> fail_index=0, fail_value=5, fail_count=2.
- start asserted during LOAD -> ignored, beat count and addresses unchanged; start in DONE -> new run, done cleared.
